iq_pack_a2f: RTL and testbench

IQ_PACK_A2F -- requirements
Module: iq_pack_a2f

---
 rtl/iq_pack_a2f.sv | 148 ++++++++++++++
 tb/tb_iq_pack_a2f.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_pack_a2f.sv
// iq_pack_a2f: packs 24-bit I/Q sample pairs into a dense stream of 32-bit
// words for the AFE-to-FT600 path. Four accepted pairs produce three words.
// A flush request emits any partial residue as one zero-padded word.
// The state encoding and the word slicing assume the default geometry
// (24-bit pairs into 32-bit words).
module iq_pack_a2f #(
    parameter int IQ_PAIR_WIDTH = 24,
    parameter int FT_DATA_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [IQ_PAIR_WIDTH-1:0] in_data_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     flush_i,
    output logic [FT_DATA_WIDTH-1:0] out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [15:0]              word_cnt_o
);

    // Residue state: number of stream bits held back, not yet emitted.
    typedef enum logic [1:0] {
        S0  = 2'd0,
        S24 = 2'd1,
        S16 = 2'd2,
        S8  = 2'd3
    } rs_t;

    rs_t                      rs_reg, rs_next;
    logic [IQ_PAIR_WIDTH-1:0] residue_reg, residue_next;
    logic                     flush_pend_reg, flush_pend_next;
    logic [FT_DATA_WIDTH-1:0] out_data_reg, out_data_next;
    logic                     out_valid_reg, out_valid_next;
    logic [15:0]              word_cnt_reg;

    logic slot_free;
    logic accept;
    logic out_hs;

    // The output register can take a new word when it is empty or being drained.
    assign slot_free = !out_valid_reg || out_ready_i;

    // A pair that completes a word needs a free output slot; a pair entering
    // S0 only fills the residue, so it never needs one. A flush request in the
    // same cycle wins, so the pair is refused rather than silently dropped.
    assign in_ready_o = !rst_i && !flush_pend_reg && !flush_i &&
                        ((rs_reg == S0) || slot_free);
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_reg && out_ready_i;

    assign out_data_o  = out_data_reg;
    assign out_valid_o = out_valid_reg;
    assign word_cnt_o  = word_cnt_reg;

    // Next-state logic: pending flush first, then new flush request, then data.
    always_comb begin
        logic                     load;
        logic [FT_DATA_WIDTH-1:0] word;

        rs_next         = rs_reg;
        residue_next    = residue_reg;
        flush_pend_next = flush_pend_reg;
        load            = 1'b0;
        word            = out_data_reg;

        if (flush_pend_reg) begin
            if (rs_reg == S0) begin
                // Nothing buffered: the flush completes without a word.
                flush_pend_next = 1'b0;
            end else if (slot_free) begin
                load            = 1'b1;
                rs_next         = S0;
                residue_next    = '0;
                flush_pend_next = 1'b0;
                case (rs_reg)
                    S24:     word = {8'h00, residue_reg[23:0]};
                    S16:     word = {16'h0000, residue_reg[15:0]};
                    S8:      word = {24'h000000, residue_reg[7:0]};
                    default: word = '0;
                endcase
            end
        end else if (flush_i) begin
            flush_pend_next = 1'b1;
        end else if (accept) begin
            case (rs_reg)
                S0: begin
                    residue_next = in_data_i;
                    rs_next      = S24;
                end
                S24: begin
                    load         = 1'b1;
                    word         = {in_data_i[7:0], residue_reg[23:0]};
                    residue_next = {8'h00, in_data_i[23:8]};
                    rs_next      = S16;
                end
                S16: begin
                    load         = 1'b1;
                    word         = {in_data_i[15:0], residue_reg[15:0]};
                    residue_next = {16'h0000, in_data_i[23:16]};
                    rs_next      = S8;
                end
                default: begin
                    load         = 1'b1;
                    word         = {in_data_i[23:0], residue_reg[7:0]};
                    residue_next = '0;
                    rs_next      = S0;
                end
            endcase
        end

        out_data_next = load ? word : out_data_reg;
        if (load) begin
            out_valid_next = 1'b1;
        end else if (out_ready_i) begin
            out_valid_next = 1'b0;
        end else begin
            out_valid_next = out_valid_reg;
        end
    end

    // State, residue and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs_reg         <= S0;
            residue_reg    <= '0;
            flush_pend_reg <= 1'b0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
        end else begin
            rs_reg         <= rs_next;
            residue_reg    <= residue_next;
            flush_pend_reg <= flush_pend_next;
            out_data_reg   <= out_data_next;
            out_valid_reg  <= out_valid_next;
        end
    end

    // Count delivered words; wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_cnt_reg <= '0;
        end else if (out_hs) begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
        end
    end

endmodule

// File: tb/tb_iq_pack_a2f.sv
// Testbench for iq_pack_a2f: directed vector table plus hand-written
// sequences for stall, flush/valid collision and mid-stream reset.
module tb_iq_pack_a2f;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] in_data_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic        flush_i = 1'b0;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [15:0] word_cnt_o;

    iq_pack_a2f #(.IQ_PAIR_WIDTH(24), .FT_DATA_WIDTH(32)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_data_i  (in_data_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .flush_i    (flush_i),
        .out_data_o (out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .word_cnt_o (word_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    int stall_seen = 0;
    logic [31:0] got[$];

    typedef struct {
        string           name;
        int              npairs;
        logic [3:0][23:0] pairs;
        bit              flush;
        int              nw;
        logic [5:0][31:0] words;
    } vec_t;

    vec_t vecs[5];

    // Capture every output handshake, sampled well after the driving edge.
    always @(negedge clk_i) begin
        #2;
        if (out_valid_o && out_ready_i && !rst_i) got.push_back(out_data_o);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic check_words(input string name, input logic [5:0][31:0] exp, input int n);
        check({name, "_count"}, got.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < got.size()) begin
                check($sformatf("%s_w%0d", name, k), got[k], exp[k]);
            end else begin
                total++;
                bad++;
                $display("FAIL %s_w%0d: got none want %h", name, k, exp[k]);
            end
        end
    endtask

    task automatic send_pair(input logic [23:0] p);
        int n = 0;
        @(negedge clk_i);
        in_data_i  = p;
        in_valid_i = 1'b1;
        #1;
        while (!in_ready_o && n < 100) begin
            stall_seen++;
            @(negedge clk_i);
            #1;
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1 for pair %h", p);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
    endtask

    task automatic do_reset(input bit verify);
        @(negedge clk_i);
        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        flush_i    = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        if (verify) begin
            check("rst_in_ready", in_ready_o, 0);
            check("rst_out_valid", out_valid_o, 0);
            check("rst_out_data", out_data_o, 0);
            check("rst_word_cnt", word_cnt_o, 0);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        got.delete();
        #1;
        if (verify) check("post_rst_in_ready", in_ready_o, 1);
    endtask

    initial begin
        logic [191:0]     stream;
        logic [5:0][31:0] exp;
        logic [23:0]      p;

        vecs[0] = '{"four_pairs", 4, {24'h444444, 24'h333333, 24'h222222, 24'h111111}, 1'b0, 3,
                    {32'h0, 32'h0, 32'h0, 32'h44444433, 32'h33332222, 32'h22111111}};
        vecs[1] = '{"one_flush", 1, {24'h0, 24'h0, 24'h0, 24'hABCDEF}, 1'b1, 1,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00ABCDEF}};
        vecs[2] = '{"two_flush", 2, {24'h0, 24'h0, 24'h222222, 24'h111111}, 1'b1, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h00002222, 32'h22111111}};
        vecs[3] = '{"three_flush", 3, {24'h0, 24'h333333, 24'h222222, 24'h111111}, 1'b1, 3,
                    {32'h0, 32'h0, 32'h0, 32'h00000033, 32'h33332222, 32'h22111111}};
        vecs[4] = '{"empty_flush", 0, {24'h0, 24'h0, 24'h0, 24'h0}, 1'b1, 0,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};

        repeat (2) @(negedge clk_i);
        do_reset(1'b1);

        // Table-driven vectors.
        for (int v = 0; v < 5; v++) begin
            do_reset(1'b0);
            for (int i = 0; i < vecs[v].npairs; i++) send_pair(vecs[v].pairs[i]);
            if (vecs[v].flush) do_flush();
            repeat (6) @(negedge clk_i);
            #3;
            check_words(vecs[v].name, vecs[v].words, vecs[v].nw);
            check({vecs[v].name, "_word_cnt"}, word_cnt_o, vecs[v].nw);
            check({vecs[v].name, "_idle_ready"}, in_ready_o, 1);
        end

        // Continuous stream with the consumer stalled for 5 cycles.
        do_reset(1'b0);
        stream = '0;
        for (int i = 0; i < 8; i++) begin
            p = 24'h0A0B0C + 24'h111111 * 24'(i);
            stream[24*i +: 24] = p;
        end
        for (int k = 0; k < 6; k++) exp[k] = stream[32*k +: 32];
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send_pair(stream[24*i +: 24]);
            end
            begin
                repeat (3) @(negedge clk_i);
                out_ready_i = 1'b0;
                repeat (5) @(negedge clk_i);
                out_ready_i = 1'b1;
            end
        join
        repeat (8) @(negedge clk_i);
        #3;
        check("stall_ready_dropped", 32'(stall_seen > 0), 1);
        check_words("stall", exp, 6);
        check("stall_word_cnt", word_cnt_o, 6);

        // Flush and valid together in S16: pad word first, pair starts at bit 0.
        do_reset(1'b0);
        send_pair(24'h111111);
        send_pair(24'h222222);
        @(negedge clk_i);
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 24'h333333;
        #1;
        check("collide_ready_low", in_ready_o, 0);
        @(posedge clk_i);
        #1;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        send_pair(24'h333333);
        send_pair(24'h444444);
        do_flush();
        repeat (6) @(negedge clk_i);
        #3;
        exp = {32'h0, 32'h0, 32'h00004444, 32'h44333333, 32'h00002222, 32'h22111111};
        check_words("collide", exp, 4);

        // Reset in S24 with an undelivered word.
        do_reset(1'b0);
        for (int i = 1; i <= 4; i++) send_pair(24'h111111 * 24'(i));
        out_ready_i = 1'b0;
        send_pair(24'h555555);
        @(negedge clk_i);
        #1;
        check("prerst_out_valid", out_valid_o, 1);
        check("prerst_word_cnt", word_cnt_o, 2);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_word_cnt", word_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        out_ready_i = 1'b1;
        got.delete();
        send_pair(24'h111111);
        do_flush();
        repeat (6) @(negedge clk_i);
        #3;
        exp = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00111111};
        check_words("after_rst", exp, 1);
        check("after_rst_word_cnt", word_cnt_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
